// File: rtl/clk_period_meter_if.sv
// Measurement bus of clk_period_meter: the slow clock under test in, and the
// period / high-time / health results out.
interface clk_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             period_valid;
  logic             in_range;
  logic             stall;
  logic [15:0]      meas_cnt;

  modport master (
    output sig_in,
    input  period, high_time, period_valid, in_range, stall, meas_cnt
  );

  modport slave (
    input  sig_in,
    output period, high_time, period_valid, in_range, stall, meas_cnt
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk cycles,
// flags out-of-tolerance periods and a stalled (missing) input clock.
module clk_period_meter #(
  parameter int WIDTH      = 32,
  parameter int EXP_PERIOD = 100_000,
  parameter int TOL        = 100,
  parameter int TIMEOUT    = 200_000
) (
  input  logic                clk,
  input  logic                rst_n,
  clk_period_meter_if.slave   bus
);

  localparam logic [WIDTH-1:0] EXP_W     = WIDTH'(EXP_PERIOD);
  localparam logic [WIDTH-1:0] TOL_W     = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Absolute difference taken larger-minus-smaller so it can never wrap.
  function automatic logic within_tol(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] diff;
    diff = (c >= EXP_W) ? (c - EXP_W) : (EXP_W - c);
    return (diff <= TOL_W);
  endfunction

  logic             s1, s2, s3;
  logic             rise, fall;
  state_t           state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] hi_lat, hi_lat_d;
  logic [WIDTH-1:0] period_r, period_d;
  logic [WIDTH-1:0] high_r, high_d;
  logic             vld_r, vld_d;
  logic             in_range_r, in_range_d;
  logic             stall_r, stall_d;
  logic [15:0]      meas_r, meas_d;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      period_r   <= '0;
      high_r     <= '0;
      vld_r      <= 1'b0;
      in_range_r <= 1'b0;
      stall_r    <= 1'b0;
      meas_r     <= '0;
    end else begin
      s1         <= bus.sig_in;
      s2         <= s1;
      s3         <= s2;
      state      <= state_d;
      cnt        <= cnt_d;
      period_r   <= period_d;
      high_r     <= high_d;
      vld_r      <= vld_d;
      in_range_r <= in_range_d;
      stall_r    <= stall_d;
      meas_r     <= meas_d;
    end
  end

  // High-phase latch is pure data; it is always rewritten before it is reported.
  always_ff @(posedge clk) begin
    hi_lat <= hi_lat_d;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hi_lat_d   = hi_lat;
    period_d   = period_r;
    high_d     = high_r;
    vld_d      = 1'b0;
    in_range_d = in_range_r;
    stall_d    = stall_r;
    meas_d     = meas_r;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d   = WIDTH'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt + WIDTH'(1);
        if (fall) begin
          hi_lat_d = cnt;
          state_d  = LOW;
        end
      end
      LOW: begin
        cnt_d = cnt + WIDTH'(1);
        if (rise) begin
          period_d   = cnt;
          high_d     = hi_lat;
          in_range_d = within_tol(cnt);
          vld_d      = 1'b1;
          meas_d     = meas_r + 16'd1;
          stall_d    = 1'b0;
          cnt_d      = WIDTH'(1);
          state_d    = HIGH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A rise landing on the timeout cycle still completes the measurement.
    if ((state != IDLE) && (cnt == TIMEOUT_W) && !rise) begin
      stall_d = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign bus.period       = period_r;
  assign bus.high_time    = high_r;
  assign bus.period_valid = vld_r;
  assign bus.in_range     = in_range_r;
  assign bus.stall        = stall_r;
  assign bus.meas_cnt     = meas_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: stimulus pushes expected measurements,
// a negedge monitor pops and compares on every period_valid pulse.
module tb_clk_period_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_period_meter_if #(.WIDTH(32)) a_if ();
  clk_period_meter_if #(.WIDTH(32)) b_if ();

  clk_period_meter #(
    .WIDTH(32), .EXP_PERIOD(20), .TOL(1), .TIMEOUT(50)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );

  clk_period_meter #(
    .WIDTH(32), .EXP_PERIOD(20), .TOL(1), .TIMEOUT(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
    logic        r;
    logic [15:0] m;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] ma = 16'd0;
  logic [15:0] mb = 16'd0;
  logic        prev_va = 1'b0;
  logic        prev_vb = 1'b0;
  int          stall_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit which, input int p, input int h, input bit r);
    exp_t e;
    e.p = p;
    e.h = h;
    e.r = r;
    if (which == 1'b0) begin
      ma  = ma + 16'd1;
      e.m = ma;
      qa.push_back(e);
    end else begin
      mb  = mb + 16'd1;
      e.m = mb;
      qb.push_back(e);
    end
  endtask

  task automatic set_sig(input bit which, input logic v);
    if (which == 1'b0) a_if.sig_in = v;
    else               b_if.sig_in = v;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One wave cycle starting with a rise; v says whether that rise completes a measurement.
  task automatic row(input bit which, input int hi, input int lo,
                     input bit v, input int p, input int h, input bit r);
    set_sig(which, 1'b1);
    if (v) push(which, p, h, r);
    wait_edges(hi);
    set_sig(which, 1'b0);
    wait_edges(lo);
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_period"},    a_if.period, 32'd0);
    chk({tag, "_high_time"}, a_if.high_time, 32'd0);
    chk({tag, "_valid"},     32'(a_if.period_valid), 32'd0);
    chk({tag, "_in_range"},  32'(a_if.in_range), 32'd0);
    chk({tag, "_stall"},     32'(a_if.stall), 32'd0);
    chk({tag, "_meas_cnt"},  32'(a_if.meas_cnt), 32'd0);
  endtask

  // Scoreboard monitor for both instances.
  always @(negedge clk) begin
    exp_t e;
    if (a_if.period_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'(a_if.period_valid), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_period",    a_if.period, e.p);
        chk("a_high_time", a_if.high_time, e.h);
        chk("a_in_range",  32'(a_if.in_range), 32'(e.r));
        chk("a_meas_cnt",  32'(a_if.meas_cnt), 32'(e.m));
        chk("a_stall_at_valid", 32'(a_if.stall), 32'd0);
      end
      chk("a_valid_one_cycle", 32'(prev_va), 32'd0);
    end
    if (b_if.period_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'(b_if.period_valid), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_period",    b_if.period, e.p);
        chk("b_high_time", b_if.high_time, e.h);
        chk("b_in_range",  32'(b_if.in_range), 32'(e.r));
        chk("b_meas_cnt",  32'(b_if.meas_cnt), 32'(e.m));
        chk("b_stall_at_valid", 32'(b_if.stall), 32'd0);
      end
      chk("b_valid_one_cycle", 32'(prev_vb), 32'd0);
    end
    prev_va = a_if.period_valid;
    prev_vb = b_if.period_valid;
  end

  initial begin
    a_if.sig_in = 1'b0;
    b_if.sig_in = 1'b0;
    rst_n = 1'b0;
    wait_edges(3);
    check_zero_a("reset");
    chk("reset_b_meas_cnt", 32'(b_if.meas_cnt), 32'd0);
    rst_n = 1'b1;
    wait_edges(2);

    // Rise landing exactly on cnt == TIMEOUT (instance B, TIMEOUT=20).
    row(1'b1, 10, 10, 1'b0, 0, 0, 1'b0);
    row(1'b1, 10, 10, 1'b1, 20, 10, 1'b1);
    row(1'b1, 10, 10, 1'b1, 20, 10, 1'b1);
    chk("b_no_stall_on_boundary", 32'(b_if.stall), 32'd0);

    // 10/10 wave: first rise only arms, then a pulse every 20 cycles.
    row(1'b0, 10, 10, 1'b0, 0, 0, 1'b0);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);

    // Tolerance edge: 21 is inside, 22 is outside.
    row(1'b0, 12, 9,  1'b1, 20, 10, 1'b1);
    row(1'b0, 12, 10, 1'b1, 21, 12, 1'b1);
    row(1'b0, 10, 10, 1'b1, 22, 12, 1'b0);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);

    // Last rise, then hold low until the stall fires 50 edges after cnt<-1.
    a_if.sig_in = 1'b1;
    push(1'b0, 20, 10, 1'b1);
    stall_at = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) a_if.sig_in = 1'b0;
      if (a_if.stall && stall_at == 0) stall_at = n;
    end
    chk("a_stall_edge", 32'(stall_at), 32'd53);
    chk("a_stall_period_hold", a_if.period, 32'd20);
    chk("a_stall_high_hold", a_if.high_time, 32'd10);
    chk("a_stall_in_range_hold", 32'(a_if.in_range), 32'd1);
    chk("a_stall_meas_hold", 32'(a_if.meas_cnt), 32'(ma));

    // Resume after stall: two rises needed, stall clears with the pulse.
    row(1'b0, 10, 10, 1'b0, 0, 0, 1'b0);
    chk("a_stall_sticky", 32'(a_if.stall), 32'd1);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);
    chk("a_stall_cleared", 32'(a_if.stall), 32'd0);

    // One-cycle reset in the middle of a high phase.
    a_if.sig_in = 1'b1;
    push(1'b0, 20, 10, 1'b1);
    wait_edges(5);
    rst_n = 1'b0;
    wait_edges(1);
    check_zero_a("midreset");
    ma = 16'd0;
    mb = 16'd0;
    rst_n = 1'b1;
    wait_edges(10);
    a_if.sig_in = 1'b0;
    wait_edges(10);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);

    // sig_in high through reset release: that rise arms the measurement.
    a_if.sig_in = 1'b1;
    rst_n = 1'b0;
    wait_edges(3);
    check_zero_a("highreset");
    ma = 16'd0;
    mb = 16'd0;
    rst_n = 1'b1;
    wait_edges(10);
    a_if.sig_in = 1'b0;
    wait_edges(10);
    row(1'b0, 10, 10, 1'b1, 20, 10, 1'b1);
    chk("a_meas_after_highreset", 32'(a_if.meas_cnt), 32'd1);

    wait_edges(5);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
